// File: rtl/and_or_cell.sv
// Bitwise AND-OR cell: combinational e = (a & b) | (c & d), plus a one-cycle
// registered copy qualified by in_valid.
module and_or_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] e_q,
    output logic             out_valid
);

    always_comb begin
        e = (a & b) | (c & d);
    end

    // e_q holds its last capture while in_valid is low; out_valid is a pure pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                e_q <= e;
            end
        end
    end

endmodule

// File: tb/tb_and_or_cell.sv
// Self-checking bench for and_or_cell: WIDTH=1 and WIDTH=8 instances driven in
// lockstep, registered results tracked through a scoreboard queue.
module tb_and_or_cell;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       a1, b1, c1, d1;
    logic       e1, e_q1, out_valid1;
    logic [7:0] a8, b8, c8, d8;
    logic [7:0] e8, e_q8;
    logic       out_valid8;

    and_or_cell #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1),
        .in_valid(in_valid), .e(e1), .e_q(e_q1), .out_valid(out_valid1)
    );

    and_or_cell #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8),
        .in_valid(in_valid), .e(e8), .e_q(e_q8), .out_valid(out_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    exp_t       sb[$];
    logic [15:0] tt = 16'hF888;  // truth table, bit index = {a,b,c,d}
    logic       m_v, m_e1;
    logic [7:0] m_e8;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] model8(input logic [7:0] xa, xb, xc, xd);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = tt[{xa[i], xb[i], xc[i], xd[i]}];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v  = 1'b0;
        m_e1 = 1'b0;
        m_e8 = '0;
        sb.delete();
    endtask

    task automatic step(input logic [3:0] v1, input logic [7:0] xa, xb, xc, xd,
                        input logic iv, input string tag);
        exp_t x;
        {a1, b1, c1, d1} = v1;
        a8 = xa; b8 = xb; c8 = xc; d8 = xd;
        in_valid = iv;
        #1;
        check({tag, "_e1"}, {7'b0, e1}, {7'b0, tt[v1]});
        check({tag, "_e8"}, e8, model8(xa, xb, xc, xd));
        if (iv) begin
            m_e1 = tt[v1];
            m_e8 = model8(xa, xb, xc, xd);
        end
        m_v = iv;
        sb.push_back('{v: m_v, e1: m_e1, e8: m_e8});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            x = sb.pop_front();
            check({tag, "_e_q1"}, {7'b0, e_q1}, {7'b0, x.e1});
            check({tag, "_ov1"}, {7'b0, out_valid1}, {7'b0, x.v});
            check({tag, "_e_q8"}, e_q8, x.e8);
            check({tag, "_ov8"}, {7'b0, out_valid8}, {7'b0, x.v});
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        {a1, b1, c1, d1} = 4'h0;
        a8 = '0; b8 = '0; c8 = '0; d8 = '0;
        model_reset();
        #1;
        check("rst_e_q1", {7'b0, e_q1}, 8'h00);
        check("rst_ov1", {7'b0, out_valid1}, 8'h00);
        check("rst_e_q8", e_q8, 8'h00);
        check("rst_ov8", {7'b0, out_valid8}, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_e_q8", e_q8, 8'h00);
        check("rst_hold_ov8", {7'b0, out_valid8}, 8'h00);
        rst = 1'b0;

        // Exhaustive truth-table sweep, back-to-back valid
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, "sweep");
        end

        // Valid gating: capture 1100, then change inputs with in_valid low
        step(4'b1100, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, "gate_cap");
        step(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "gate_hold");
        check("gate_e_q1_const", {7'b0, e_q1}, 8'h01);
        check("gate_e_q8_const", e_q8, 8'hFF);

        // Wide bitwise pattern
        step(4'b1010, 8'hF0, 8'hCC, 8'h0F, 8'hAA, 1'b1, "wide");
        check("wide_e8_const", e8, 8'hCA);
        check("wide_e_q8_const", e_q8, 8'hCA);

        // Reset asserted between edges with a valid capture pending
        step(4'hF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, "pre_rst");
        {a1, b1, c1, d1} = 4'hF;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF;
        in_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_e_q1", {7'b0, e_q1}, 8'h00);
        check("midrst_ov1", {7'b0, out_valid1}, 8'h00);
        check("midrst_e_q8", e_q8, 8'h00);
        check("midrst_ov8", {7'b0, out_valid8}, 8'h00);
        check("midrst_e1", {7'b0, e1}, 8'h01);
        check("midrst_e8", e8, 8'hFF);
        model_reset();
        @(posedge clk);
        #1;
        check("midrst_hold_e_q1", {7'b0, e_q1}, 8'h00);
        check("midrst_hold_ov1", {7'b0, out_valid1}, 8'h00);
        rst = 1'b0;
        step(4'hF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, "post_rst");
        check("post_rst_e_q1_const", {7'b0, e_q1}, 8'h01);

        // Idle cycle after release: no stale data, out_valid drops
        step(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "idle");

        // Streaming: 16 random valid vectors on consecutive cycles
        for (int i = 0; i < 16; i++) begin
            step(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 1'b1, "stream");
        end

        check("sb_drained", 8'(sb.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
